// File: rtl/msf_frame_assembler.sv
// msf_frame_assembler
//   Aligns the per-second beats from the MSF decoder into one-minute frames,
//   shifts the BCD time/date fields out of A bits 17-51, accumulates the four
//   odd-parity checks (A ranges plus B bits 54-57), and on the next minute
//   marker publishes the decoded time if the frame was good.
//
//   Optional feature macro: MSF_MARKER_CHECK_EN
//     When defined, A bits of seconds 52-59 are captured and must read
//     8'b01111110 for a frame to be accepted.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   bits_valid_i           one-cycle strobe per received second
//   bits_is_second_00_i    qualifies bits_valid_i as the minute marker
//   bits_data_i[1:0]       [1]=A bit, [0]=B bit (ignored on marker beats)
//   time_valid_o           one-cycle pulse: output fields just updated
//   sync_o                 last frame good, no error/timeout since
//   frame_err_o            one-cycle pulse: frame rejected or timeout
//   year_o .. minute_o     BCD time/date of last good frame
//   dow_o                  day of week 0-6
//   bst_o                  B bit of second 58 (summer time)
module msf_frame_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bits_valid_i,
  input  logic       bits_is_second_00_i,
  input  logic [1:0] bits_data_i,
  output logic       time_valid_o,
  output logic       sync_o,
  output logic       frame_err_o,
  output logic [7:0] year_o,
  output logic [4:0] month_o,
  output logic [5:0] day_o,
  output logic [2:0] dow_o,
  output logic [5:0] hour_o,
  output logic [6:0] minute_o,
  output logic       bst_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t          state;
  logic [5:0]      sec_cnt;
  logic [3:0]      par;
  logic [7:0]      year_sh;
  logic [4:0]      month_sh;
  logic [5:0]      day_sh;
  logic [2:0]      dow_sh;
  logic [5:0]      hour_sh;
  logic [6:0]      minute_sh;
  logic            bst_sh;
  logic [TW-1:0]   tmo_cnt;
`ifdef MSF_MARKER_CHECK_EN
  logic [7:0]      mark_sh;
`endif

  logic       a_bit;
  logic       b_bit;
  logic [5:0] sec_next;
  logic       marker_ok;
  logic       frame_good;

  assign a_bit    = bits_data_i[1];
  assign b_bit    = bits_data_i[0];
  assign sec_next = sec_cnt + 6'd1;

`ifdef MSF_MARKER_CHECK_EN
  assign marker_ok = (mark_sh == 8'b0111_1110);
`else
  assign marker_ok = 1'b1;
`endif

  // Exactly 59 data seconds seen and all four groups have odd parity.
  assign frame_good = (sec_cnt == 6'd59) && (&par) && marker_ok;

  // Frame sequencer, field shifters, parity and timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= HUNT;
      sec_cnt      <= '0;
      par          <= '0;
      year_sh      <= '0;
      month_sh     <= '0;
      day_sh       <= '0;
      dow_sh       <= '0;
      hour_sh      <= '0;
      minute_sh    <= '0;
      bst_sh       <= 1'b0;
      tmo_cnt      <= '0;
      time_valid_o <= 1'b0;
      sync_o       <= 1'b0;
      frame_err_o  <= 1'b0;
      year_o       <= '0;
      month_o      <= '0;
      day_o        <= '0;
      dow_o        <= '0;
      hour_o       <= '0;
      minute_o     <= '0;
      bst_o        <= 1'b0;
`ifdef MSF_MARKER_CHECK_EN
      mark_sh      <= '0;
`endif
    end else begin
      time_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      if (bits_valid_i) begin
        tmo_cnt <= '0;
        if (bits_is_second_00_i) begin
          // Marker closes the running frame (if any) and opens a new one.
          if (state == COLLECT) begin
            if (frame_good) begin
              year_o       <= year_sh;
              month_o      <= month_sh;
              day_o        <= day_sh;
              dow_o        <= dow_sh;
              hour_o       <= hour_sh;
              minute_o     <= minute_sh;
              bst_o        <= bst_sh;
              time_valid_o <= 1'b1;
              sync_o       <= 1'b1;
            end else begin
              frame_err_o  <= 1'b1;
              sync_o       <= 1'b0;
            end
          end
          state     <= COLLECT;
          sec_cnt   <= '0;
          par       <= '0;
          year_sh   <= '0;
          month_sh  <= '0;
          day_sh    <= '0;
          dow_sh    <= '0;
          hour_sh   <= '0;
          minute_sh <= '0;
          bst_sh    <= 1'b0;
`ifdef MSF_MARKER_CHECK_EN
          mark_sh   <= '0;
`endif
        end else if (state == COLLECT) begin
          if (sec_cnt == 6'd59) begin
            // Long minute: no marker where one was due.
            frame_err_o <= 1'b1;
            sync_o      <= 1'b0;
            state       <= HUNT;
          end else begin
            sec_cnt <= sec_next;
            if (sec_next >= 6'd17 && sec_next <= 6'd24) begin
              year_sh <= {year_sh[6:0], a_bit};
              par[0]  <= par[0] ^ a_bit;
            end else if (sec_next >= 6'd25 && sec_next <= 6'd29) begin
              month_sh <= {month_sh[3:0], a_bit};
              par[1]   <= par[1] ^ a_bit;
            end else if (sec_next >= 6'd30 && sec_next <= 6'd35) begin
              day_sh <= {day_sh[4:0], a_bit};
              par[1] <= par[1] ^ a_bit;
            end else if (sec_next >= 6'd36 && sec_next <= 6'd38) begin
              dow_sh <= {dow_sh[1:0], a_bit};
              par[2] <= par[2] ^ a_bit;
            end else if (sec_next >= 6'd39 && sec_next <= 6'd44) begin
              hour_sh <= {hour_sh[4:0], a_bit};
              par[3]  <= par[3] ^ a_bit;
            end else if (sec_next >= 6'd45 && sec_next <= 6'd51) begin
              minute_sh <= {minute_sh[5:0], a_bit};
              par[3]    <= par[3] ^ a_bit;
            end else if (sec_next >= 6'd54 && sec_next <= 6'd57) begin
              // B bits 54..57 are the parity bits for groups 1..4.
              par[2'(sec_next - 6'd54)] <= par[2'(sec_next - 6'd54)] ^ b_bit;
            end else if (sec_next == 6'd58) begin
              bst_sh <= b_bit;
            end
`ifdef MSF_MARKER_CHECK_EN
            if (sec_next >= 6'd52) begin
              mark_sh <= {mark_sh[6:0], a_bit};
            end
`endif
          end
        end
      end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
        // Count idle cycles; the expiry cycle fires once then saturates.
        tmo_cnt <= tmo_cnt + TW'(1);
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state       <= HUNT;
          sync_o      <= 1'b0;
          frame_err_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/msf_frame_assembler.md
Name: msf_frame_assembler

Overview:
- Sequences the per-second output of the MSF decoder into whole one-minute frames.
- Tracks the second index from the second-00 marker and shifts A bits 17–51 into BCD time fields.
- Accumulates the four odd-parity checks carried in B bits 54–57.
- On the next second-00 marker, latches a validated time/date and pulses time_valid_o. Sits between decoder and the display/output formatter.

Parameters:
- TIMEOUT_CYCLES, 65536: clk cycles with no bits_valid_i before sync is dropped. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- bits_valid_i  input  1  one-cycle strobe, one per received second
- bits_is_second_00_i  input  1  qualifies bits_valid_i: this beat is the minute marker
- bits_data_i  input  2  [1]=A bit, [0]=B bit of the current second; ignored on marker beats
- time_valid_o  output  1  one-cycle pulse: time fields just updated
- sync_o  output  1  1 = last frame decoded good and no error/timeout since
- frame_err_o  output  1  one-cycle pulse: frame rejected (length, parity or marker)
- year_o  output  8  BCD year 00–99
- month_o  output  5  BCD month
- day_o  output  6  BCD day of month
- dow_o  output  3  day of week 0–6
- hour_o  output  6  BCD hour
- minute_o  output  7  BCD minute
- bst_o  output  1  B bit of second 58 (summer time in effect)

Behaviour:
- Reset: all outputs 0, state HUNT, sec_cnt=0, parity accumulators 0, timeout counter 0.
- States: HUNT (no frame alignment) and COLLECT (sec_cnt = last second index received, 0–59).
- HUNT: non-marker beats are ignored. A marker beat goes to COLLECT with sec_cnt=0, no output pulses.
- COLLECT, non-marker beat:
  - sec_cnt increments. The new index n selects the action.
  - n=17..51: A bit shifted MSB-first into the field it belongs to: year 17–24, month 25–29, day 30–35, dow 36–38, hour 39–44, minute 45–51.
  - Running parity: P1 ^= A for 17–24; P2 ^= A for 25–35; P3 ^= A for 36–38; P4 ^= A for 39–51.
  - n=54..57: B bit XORed into P1..P4 respectively.
  - n=58: B latched as bst candidate.
  - A beat arriving when sec_cnt=59 (would be n=60) is a frame error: frame_err_o pulses and state goes to HUNT.
- COLLECT, marker beat:
  - Frame is good iff sec_cnt==59 and P1=P2=P3=P4=1 (odd parity), plus the marker check when enabled.
  - Good frame: the cycle after the beat, output fields load from the shift fields, time_valid_o pulses, and sync_o goes to 1.
  - Bad frame: frame_err_o pulses and sync_o goes to 0. Outputs hold their last good values.
  - In both cases: sec_cnt=0, accumulators and shift fields cleared, remain in COLLECT.
- Latency: time_valid_o and frame_err_o are exactly 1 clk after the triggering bits_valid_i. Never both in the same cycle.
- Timeout:
  - The counter clears on every bits_valid_i and increments otherwise.
  - On reaching TIMEOUT_CYCLES: state goes to HUNT, sync_o=0, frame_err_o pulses once, and the counter saturates until the next beat.
  - If bits_valid_i arrives in the same cycle as expiry, the beat wins: it is processed and the counter clears.
- Short (leap-negative) or long minutes: rejected by the sec_cnt rules above, then resync from the marker.
- Reset asserted mid-frame: full return to reset state, including the output fields.

Optional Feature:
- Macro MSF_MARKER_CHECK_EN.
- When defined: the A bits of seconds 52–59 are captured and must equal 8'b01111110 for a frame to be good. A mismatch gives frame_err_o, as a parity failure does.
- When undefined: A bits 52–59 are ignored and no capture register is synthesised.

Test Plan:
- Reset, marker, then 59 beats encoding 23-03-15, dow 3, 14:37, BST=1, correct parity and marker, then marker:
  - 1 clk later time_valid_o=1 and sync_o=1.
  - year_o=8'h23, month_o=5'h03, day_o=6'h15, dow_o=3, hour_o=6'h14, minute_o=7'h37, bst_o=1.
- Same frame with the hour bit at second 44 flipped (P4 wrong):
  - frame_err_o pulses, sync_o=0, outputs keep their previous values, time_valid_o stays 0.
- Good frame, then a marker after only 58 non-marker beats: frame_err_o pulses. The next full good frame restores sync_o=1.
- In COLLECT, send a 60th non-marker beat: frame_err_o pulses. Beats are ignored until a marker arrives, then a good frame decodes.
- After sync, withhold bits_valid_i for TIMEOUT_CYCLES (bench override 100) cycles:
  - At cycle 100, frame_err_o pulses once and sync_o=0, and the fields are retained.
  - A beat exactly on cycle 100 prevents the timeout.
- With MSF_MARKER_CHECK_EN, a good frame with A at second 52 = 1: frame_err_o. Without the macro the same frame decodes good.
